serial_framer: RTL and testbench

Serial-to-parallel framer that sits directly downstream of the negedge-clocked D flip-flop stage and consumes its `q` output as a serial bitstream. It hunts for a sync word, then assembles a fixed number of data words MSB-first. Each word is presented on a valid/ready output port with a one-word holding register. It returns to hunting after each frame.

---
 rtl/serial_framer.sv | 111 +++++++++++
 tb/tb_serial_framer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_framer.sv
// Serial-to-parallel framer: hunts for SYNC_WORD in a strobed bitstream, then assembles
// FRAME_WORDS words MSB-first into a one-word valid/ready holding register.
module serial_framer #(
   parameter int unsigned      WIDTH       = 8,
   parameter logic [WIDTH-1:0] SYNC_WORD   = 8'hA5,
   parameter int unsigned      FRAME_WORDS = 4
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             din,
   input  logic             din_en,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   input  logic             data_ready,
   output logic             locked,
   output logic             overrun
);

   localparam int unsigned BW = $clog2(WIDTH);
   localparam int unsigned FW = $clog2(WIDTH + 1);
   localparam int unsigned WW = $clog2(FRAME_WORDS + 1);

   localparam logic [BW-1:0] BitLast  = BW'(WIDTH - 1);
   localparam logic [FW-1:0] FillFull = FW'(WIDTH);
   localparam logic [FW-1:0] FillPrev = FW'(WIDTH - 1);
   localparam logic [WW-1:0] WordLast = WW'(FRAME_WORDS - 1);

   typedef enum logic {StHunt, StLocked} state_e;

   state_e           r_state;
   logic [WIDTH-1:0] r_sr;
   logic [FW-1:0]    r_fill;
   logic [BW-1:0]    r_bit_cnt;
   logic [WW-1:0]    r_word_cnt;
   logic [WIDTH-1:0] r_data_out;
   logic             r_data_valid;
   logic             r_overrun;

   logic [WIDTH-1:0] w_sr_next;
   logic             w_filled;
   logic             w_sync_hit;
   logic             w_word_done;

   assign w_sr_next = {r_sr[WIDTH-2:0], din};
   // Fill counts the current bit too, so one short of full is already enough.
   assign w_filled    = (r_fill == FillFull) || (r_fill == FillPrev);
   assign w_sync_hit  = (r_state == StHunt) && din_en && w_filled && (w_sr_next == SYNC_WORD);
   assign w_word_done = (r_state == StLocked) && din_en && (r_bit_cnt == BitLast);

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         r_state      <= StHunt;
         r_sr         <= '0;
         r_fill       <= '0;
         r_bit_cnt    <= '0;
         r_word_cnt   <= '0;
         r_data_out   <= '0;
         r_data_valid <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         if (din_en) begin
            r_sr <= w_sr_next;
            if (r_fill != FillFull) begin
               r_fill <= r_fill + FW'(1);
            end
         end

         unique case (r_state)
            StHunt: begin
               if (w_sync_hit) begin
                  r_state    <= StLocked;
                  r_bit_cnt  <= '0;
                  r_word_cnt <= '0;
               end
            end
            StLocked: begin
               if (din_en) begin
                  if (r_bit_cnt == BitLast) begin
                     r_bit_cnt  <= '0;
                     r_word_cnt <= r_word_cnt + WW'(1);
                     if (r_word_cnt == WordLast) begin
                        r_state <= StHunt;
                        r_fill  <= '0;
                     end
                  end else begin
                     r_bit_cnt <= r_bit_cnt + BW'(1);
                  end
               end
            end
         endcase

         // A completed word only lands if the holding register is free this edge.
         if (w_word_done) begin
            if (!r_data_valid || data_ready) begin
               r_data_out   <= w_sr_next;
               r_data_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_data_valid && data_ready) begin
            r_data_valid <= 1'b0;
         end
      end
   end

   assign data_out   = r_data_out;
   assign data_valid = r_data_valid;
   assign locked     = (r_state == StLocked);
   assign overrun    = r_overrun;

endmodule

// File: tb/tb_serial_framer.sv
// Self-checking bench for serial_framer: table-driven frames, hand-written corner
// sequences and a randomized stream checked against a bit-queue reference model.
module tb_serial_framer;

   logic       clk = 1'b0;
   logic       clear;
   logic       din;
   logic       din_en;
   logic [7:0] data_out;
   logic       data_valid;
   logic       data_ready;
   logic       locked;
   logic       overrun;

   int checks = 0;
   int errors = 0;

   bit         bit_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];

   typedef struct {
      int         lead_n;
      logic [7:0] lead;
      logic [7:0] d   [4];
      bit         gaps;
      logic [7:0] exp [4];
   } vec_t;

   vec_t tbl[4];

   serial_framer #(
      .WIDTH      (8),
      .SYNC_WORD  (8'hA5),
      .FRAME_WORDS(4)
   ) dut (
      .clk       (clk),
      .clear     (clear),
      .din       (din),
      .din_en    (din_en),
      .data_out  (data_out),
      .data_valid(data_valid),
      .data_ready(data_ready),
      .locked    (locked),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   // Each negedge with valid&ready corresponds to exactly one acceptance at the next posedge.
   always @(negedge clk) begin
      if (clear && data_valid && data_ready) got_q.push_back(data_out);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Called one time unit after a posedge; returns just after the edge that consumed the bit.
   task automatic send_bit(input bit b, input bit en);
      din    = b;
      din_en = en;
      if (en) bit_q.push_back(b);
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [7:0] w, input bit gaps);
      for (int i = 7; i >= 0; i--) begin
         if (gaps && ($urandom_range(0, 1) == 1)) send_bit(1'($urandom_range(0, 1)), 1'b0);
         send_bit(w[i], 1'b1);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
   endtask

   task automatic do_reset();
      clear      = 1'b0;
      din        = 1'b0;
      din_en     = 1'b0;
      data_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      clear = 1'b1;
      got_q.delete();
      bit_q.delete();
   endtask

   task automatic compare_q(input string name);
      int n;
      check({name, "_count"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check({name, "_word"}, got_q[i], exp_q[i]);
   endtask

   // Reference: scan consumed bits; a sync needs 8 bits since the hunt began, then the
   // following 32 bits are four words, and hunting restarts from an empty window.
   function automatic void model();
      int         fill = 0;
      int         i    = 0;
      logic [7:0] win  = '0;
      logic [7:0] w;
      exp_q.delete();
      while (i < bit_q.size()) begin
         win = {win[6:0], 1'(bit_q[i])};
         fill++;
         i++;
         if (fill >= 8 && win == 8'hA5) begin
            for (int k = 0; k < 4; k++) begin
               if (i + 8 * (k + 1) <= bit_q.size()) begin
                  for (int b = 0; b < 8; b++) w[7-b] = 1'(bit_q[i + 8 * k + b]);
                  exp_q.push_back(w);
               end
            end
            i    = i + 32;
            fill = 0;
         end
      end
   endfunction

   initial begin
      logic [7:0] sync;
      logic [7:0] words[4];
      sync  = 8'hA5;
      words = '{8'h3C, 8'hC3, 8'h01, 8'hFF};

      tbl[0] = '{0, 8'h00, '{8'h3C, 8'hC3, 8'h01, 8'hFF}, 1'b0, '{8'h3C, 8'hC3, 8'h01, 8'hFF}};
      tbl[1] = '{3, 8'h05, '{8'h12, 8'h34, 8'h56, 8'h78}, 1'b0, '{8'h12, 8'h34, 8'h56, 8'h78}};
      tbl[2] = '{0, 8'h00, '{8'h3C, 8'hC3, 8'h01, 8'hFF}, 1'b1, '{8'h3C, 8'hC3, 8'h01, 8'hFF}};
      tbl[3] = '{5, 8'h1A, '{8'hA5, 8'h00, 8'h5A, 8'hA5}, 1'b1, '{8'hA5, 8'h00, 8'h5A, 8'hA5}};

      clear = 1'b0;
      #1;
      do_reset();
      check("rst_locked", locked, 0);
      check("rst_valid", data_valid, 0);
      check("rst_data", data_out, 0);
      check("rst_overrun", overrun, 0);

      // Nominal frame with cycle-exact lock and valid-pulse checks.
      for (int i = 7; i >= 1; i--) send_bit(sync[i], 1'b1);
      check("lock_early", locked, 0);
      send_bit(sync[0], 1'b1);
      check("lock_rise", locked, 1);
      for (int k = 0; k < 4; k++) begin
         send_word(words[k], 1'b0);
         check("nom_valid", data_valid, 1);
         check("nom_data", data_out, {24'h0, words[k]});
         check("nom_locked", locked, (k < 3) ? 1 : 0);
         idle(1);
         check("nom_pulse", data_valid, 0);
      end

      // Table-driven frames: plain, misaligned, strobe gaps, sync value as data.
      for (int v = 0; v < 4; v++) begin
         do_reset();
         for (int i = tbl[v].lead_n - 1; i >= 0; i--) send_bit(tbl[v].lead[i], 1'b1);
         send_word(sync, tbl[v].gaps);
         check("tbl_lock", locked, 1);
         for (int k = 0; k < 4; k++) send_word(tbl[v].d[k], tbl[v].gaps);
         check("tbl_unlock", locked, 0);
         idle(2);
         exp_q.delete();
         for (int k = 0; k < 4; k++) exp_q.push_back(tbl[v].exp[k]);
         compare_q("tbl_words");
         check("tbl_overrun", overrun, 0);
      end

      // Backpressure: first word held, later words dropped, overrun sticky.
      do_reset();
      data_ready = 1'b0;
      send_word(sync, 1'b0);
      send_word(8'h3C, 1'b0);
      check("bp_valid", data_valid, 1);
      check("bp_ovr_pre", overrun, 0);
      send_word(8'hC3, 1'b0);
      check("bp_overrun", overrun, 1);
      check("bp_hold", data_out, 8'h3C);
      send_word(8'h01, 1'b0);
      send_word(8'hFF, 1'b0);
      check("bp_unlock", locked, 0);
      check("bp_hold2", data_out, 8'h3C);
      data_ready = 1'b1;
      idle(1);
      check("bp_consumed", data_valid, 0);
      idle(2);
      check("bp_no_more", data_valid, 0);
      check("bp_sticky", overrun, 1);
      exp_q.delete();
      exp_q.push_back(8'h3C);
      compare_q("bp_words");

      // Asynchronous reset between edges clears everything at once.
      data_ready = 1'b0;
      send_word(sync, 1'b0);
      send_word(8'h66, 1'b0);
      #2;
      clear = 1'b0;
      #1;
      check("async_locked", locked, 0);
      check("async_valid", data_valid, 0);
      check("async_data", data_out, 0);
      check("async_overrun", overrun, 0);
      @(posedge clk);
      #1;
      clear      = 1'b1;
      data_ready = 1'b1;

      // Reset mid-frame, then stale bits must not produce data before a fresh sync.
      do_reset();
      send_word(sync, 1'b0);
      send_word(8'h12, 1'b0);
      for (int i = 7; i >= 4; i--) send_bit(1'(i[0]), 1'b1);
      check("mid_locked", locked, 1);
      #2;
      clear = 1'b0;
      #1;
      check("mid_rst_locked", locked, 0);
      check("mid_rst_valid", data_valid, 0);
      @(posedge clk);
      #1;
      clear = 1'b1;
      got_q.delete();
      send_word(8'h3C, 1'b0);
      check("mid_no_lock", locked, 0);
      send_word(sync, 1'b0);
      check("mid_relock", locked, 1);
      send_word(8'hAA, 1'b0);
      send_word(8'hBB, 1'b0);
      send_word(8'hCC, 1'b0);
      send_word(8'hDD, 1'b0);
      idle(2);
      exp_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      compare_q("mid_words");

      // Randomized stream with gaps against the reference model.
      do_reset();
      for (int seg = 0; seg < 40; seg++) begin
         if ($urandom_range(0, 2) == 0) begin
            send_word(sync, 1'b1);
            for (int k = 0; k < 4; k++) send_word(8'($urandom), 1'b1);
         end else begin
            for (int b = 0; b < int'($urandom_range(1, 20)); b++) begin
               if ($urandom_range(0, 1) == 1) send_bit(1'($urandom_range(0, 1)), 1'b0);
               send_bit(1'($urandom_range(0, 1)), 1'b1);
            end
         end
      end
      idle(3);
      model();
      compare_q("rand_words");
      check("rand_overrun", overrun, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
